cp0_exc_ctrl: RTL and testbench

- Coprocessor-0 exception/interrupt controller for the pipelined MIPS core.
- Consumes the exception sources raised in the datapath (ALU overflow Ov, address errors, reserved instruction) plus external hardware interrupts.
- Decides whether to take an exception, then holds SR/Cause/EPC/PRId.
- Sits at the M stage; mfc0/mtc0/eret access it; the pipeline flush and PC redirect are driven from its request output.

---
 rtl/cp0_pkg.sv | 27 ++
 rtl/cp0_timer.sv | 36 +++
 rtl/cp0_exc_ctrl.sv | 121 ++++++++++++
 tb/tb_cp0_exc_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 register numbers, field positions and exception codes.
package cp0_pkg;

    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_SR      = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;
    localparam logic [4:0] REG_PRID    = 5'd15;

    localparam int IM_HI  = 15;
    localparam int IM_LO  = 10;
    localparam int EXL    = 1;
    localparam int IE     = 0;
    localparam int BD     = 31;
    localparam int EXC_HI = 6;
    localparam int EXC_LO = 2;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exccode_e;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count free-runs, timer_pend latches one cycle after a match.
// A write to Compare clears the pending flag and wins over a same-cycle match.
module cp0_timer
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] din,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_pend
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count      <= '0;
            compare    <= '0;
            timer_pend <= 1'b0;
        end else begin
            if (we && addr == REG_COUNT)
                count <= din;
            else
                count <= count + 32'd1;

            if (we && addr == REG_COMPARE) begin
                compare    <= din;
                timer_pend <= 1'b0;
            end else if (count == compare) begin
                timer_pend <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller: SR/Cause/EPC/PRId, zero-latency req, mfc0 read is combinational.
// Build option CP0_TIMER_EN adds Count/Compare with the timer folded into interrupt line 5.
module cp0_exc_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID       = 32'h2022_0007,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    input  logic [31:0] vpc,
    input  logic        bd_in,
    input  logic [4:0]  exccode_in,
    input  logic [5:0]  hwint,
    input  logic        eret,
    output logic        req,
    output logic [31:0] epc_out,
    output logic [31:0] handler_pc
);

    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc;

    logic [5:0]  ip_next;
    logic        int_req;
    logic        exc_req;
    logic        wr_en;

    assign int_req = (|(cause_ip & sr_im)) & sr_ie & ~sr_exl;
    assign exc_req = (exccode_in != 5'd0) & ~sr_exl;
    assign req     = int_req | exc_req;
    // An mtc0 only lands when neither an exception nor an eret owns this edge.
    assign wr_en   = we & ~req & ~eret;

`ifdef CP0_TIMER_EN
    logic [31:0] count;
    logic [31:0] compare;
    logic        timer_pend;

    cp0_timer u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .we         (wr_en),
        .addr       (addr),
        .din        (din),
        .count      (count),
        .compare    (compare),
        .timer_pend (timer_pend)
    );

    assign ip_next = {hwint[5] | timer_pend, hwint[4:0]};
`else
    assign ip_next = hwint;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr_im     <= '0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= '0;
            cause_exc <= '0;
            epc       <= '0;
        end else begin
            cause_ip <= ip_next;
            if (req) begin
                sr_exl    <= 1'b1;
                cause_bd  <= bd_in;
                cause_exc <= int_req ? EXC_INT : exccode_in;
                epc       <= bd_in ? vpc - 32'd4 : vpc;
            end else if (eret) begin
                sr_exl <= 1'b0;
            end else if (wr_en) begin
                if (addr == REG_SR) begin
                    sr_im  <= din[IM_HI:IM_LO];
                    sr_exl <= din[EXL];
                    sr_ie  <= din[IE];
                end else if (addr == REG_EPC) begin
                    epc <= din;
                end
            end
        end
    end

    always_comb begin
        dout = '0;
        case (addr)
            REG_SR: begin
                dout[IM_HI:IM_LO] = sr_im;
                dout[EXL]         = sr_exl;
                dout[IE]          = sr_ie;
            end
            REG_CAUSE: begin
                dout[BD]            = cause_bd;
                dout[IM_HI:IM_LO]   = cause_ip;
                dout[EXC_HI:EXC_LO] = cause_exc;
            end
            REG_EPC:     dout = epc;
            REG_PRID:    dout = PRID;
`ifdef CP0_TIMER_EN
            REG_COUNT:   dout = count;
            REG_COMPARE: dout = compare;
`endif
            default:     dout = '0;
        endcase
    end

    assign epc_out    = epc;
    assign handler_pc = HANDLER_PC;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Bench for cp0_exc_ctrl: cycle table with scoreboard, then async-reset and timer sequences.
module tb_cp0_exc_ctrl;

    localparam logic [31:0] PRID = 32'h2022_0007;
    localparam logic [31:0] HPC  = 32'h0000_4180;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic [31:0] vpc;
    logic        bd_in;
    logic [4:0]  exccode_in;
    logic [5:0]  hwint;
    logic        eret;
    logic        req;
    logic [31:0] epc_out;
    logic [31:0] handler_pc;

    int total = 0;
    int bad   = 0;

    cp0_exc_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .we         (we),
        .addr       (addr),
        .din        (din),
        .dout       (dout),
        .vpc        (vpc),
        .bd_in      (bd_in),
        .exccode_in (exccode_in),
        .hwint      (hwint),
        .eret       (eret),
        .req        (req),
        .epc_out    (epc_out),
        .handler_pc (handler_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] din;
        logic [31:0] vpc;
        logic        bd;
        logic [4:0]  exc;
        logic [5:0]  hw;
        logic        eret;
        logic        req;
        logic [31:0] dout;
        logic [31:0] epc;
    } vec_t;

    typedef struct {
        string       tag;
        logic        req;
        logic [31:0] dout;
        logic [31:0] epc;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    function automatic vec_t mk(input logic w, input logic [4:0] a, input logic [31:0] d,
                                input logic [31:0] pc, input logic bd, input logic [4:0] ex,
                                input logic [5:0] hw, input logic er, input logic rq,
                                input logic [31:0] dv, input logic [31:0] ep);
        vec_t v;
        v.we = w; v.addr = a; v.din = d; v.vpc = pc; v.bd = bd; v.exc = ex;
        v.hw = hw; v.eret = er; v.req = rq; v.dout = dv; v.epc = ep;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        we = v.we; addr = v.addr; din = v.din; vpc = v.vpc; bd_in = v.bd;
        exccode_in = v.exc; hwint = v.hw; eret = v.eret;
    endtask

    task automatic idle();
        we = 1'b0; addr = 5'd0; din = '0; vpc = '0; bd_in = 1'b0;
        exccode_in = '0; hwint = '0; eret = 1'b0;
    endtask

    initial begin
        exp_t e;
        reset_n = 1'b0;
        idle();
        addr = 5'd12;

        // Each row: inputs for one cycle, expected req/dout/epc_out before the edge.
        //                we a   din            vpc           bd ex  hw  er  req dout           epc
        tbl.push_back(mk(1, 11, 32'hFFFF_FFFF, 32'h0,        0, 0,  0,  0,  0, 32'h0,         32'h0));
        tbl.push_back(mk(0, 15, 32'h0,         32'h0,        0, 0,  0,  0,  0, PRID,          32'h0));
        tbl.push_back(mk(0, 13, 32'h0,         32'h3008,     0, 12, 0,  0,  1, 32'h0,         32'h0));
        tbl.push_back(mk(0, 13, 32'h0,         32'h3008,     0, 12, 0,  0,  0, 32'h30,        32'h3008));
        tbl.push_back(mk(0, 12, 32'h0,         32'h0,        0, 0,  0,  0,  0, 32'h2,         32'h3008));
        tbl.push_back(mk(0, 12, 32'h0,         32'h0,        0, 0,  0,  1,  0, 32'h2,         32'h3008));
        tbl.push_back(mk(0, 12, 32'h0,         32'h0,        0, 0,  0,  0,  0, 32'h0,         32'h3008));
        tbl.push_back(mk(0, 14, 32'h0,         32'h3010,     1, 10, 0,  0,  1, 32'h3008,      32'h3008));
        tbl.push_back(mk(0, 13, 32'h0,         32'h0,        0, 0,  0,  0,  0, 32'h8000_0028, 32'h300C));
        tbl.push_back(mk(0, 14, 32'h0,         32'h0,        0, 0,  0,  1,  0, 32'h300C,      32'h300C));
        tbl.push_back(mk(1, 12, 32'h0000_0401, 32'h0,        0, 0,  1,  0,  0, 32'h0,         32'h300C));
        tbl.push_back(mk(0, 13, 32'h0,         32'h3020,     0, 4,  1,  0,  1, 32'h8000_0428, 32'h300C));
        tbl.push_back(mk(0, 13, 32'h0,         32'h3020,     0, 4,  1,  0,  0, 32'h400,       32'h3020));
        tbl.push_back(mk(0, 12, 32'h0,         32'h0,        0, 0,  0,  0,  0, 32'h403,       32'h3020));
        tbl.push_back(mk(0, 12, 32'h0,         32'h0,        0, 0,  0,  1,  0, 32'h403,       32'h3020));
        tbl.push_back(mk(1, 14, 32'h1234,      32'h3040,     0, 5,  0,  1,  1, 32'h3020,      32'h3020));
        tbl.push_back(mk(0, 14, 32'h0,         32'h0,        0, 0,  0,  0,  0, 32'h3040,      32'h3040));
        tbl.push_back(mk(0, 12, 32'h0,         32'h0,        0, 0,  0,  0,  0, 32'h403,       32'h3040));
        tbl.push_back(mk(0, 12, 32'h0,         32'h0,        0, 0,  0,  1,  0, 32'h403,       32'h3040));
        tbl.push_back(mk(0, 12, 32'h0,         32'h0,        0, 0,  0,  0,  0, 32'h401,       32'h3040));
        tbl.push_back(mk(1, 14, 32'hDEAD_BEEF, 32'h0,        0, 0,  0,  0,  0, 32'h3040,      32'h3040));
        tbl.push_back(mk(0, 14, 32'h0,         32'h0,        0, 0,  0,  0,  0, 32'hDEAD_BEEF, 32'hDEAD_BEEF));
        tbl.push_back(mk(1, 13, 32'hFFFF_FFFF, 32'h0,        0, 0,  0,  0,  0, 32'h14,        32'hDEAD_BEEF));
        tbl.push_back(mk(0, 13, 32'h0,         32'h0,        0, 0,  0,  0,  0, 32'h14,        32'hDEAD_BEEF));
        tbl.push_back(mk(1, 15, 32'h0,         32'h0,        0, 0,  0,  0,  0, PRID,          32'hDEAD_BEEF));
        tbl.push_back(mk(0, 15, 32'h0,         32'h0,        0, 0,  0,  0,  0, PRID,          32'hDEAD_BEEF));
        tbl.push_back(mk(1, 20, 32'h5,         32'h0,        0, 0,  0,  0,  0, 32'h0,         32'hDEAD_BEEF));
        tbl.push_back(mk(0, 20, 32'h0,         32'h0,        0, 0,  0,  0,  0, 32'h0,         32'hDEAD_BEEF));
        tbl.push_back(mk(1, 12, 32'hFFFF_FFFF, 32'h0,        0, 0,  0,  0,  0, 32'h401,       32'hDEAD_BEEF));
        tbl.push_back(mk(0, 12, 32'h0,         32'h0,        0, 0,  0,  0,  0, 32'hFC03,      32'hDEAD_BEEF));
        tbl.push_back(mk(1, 12, 32'h0,         32'h0,        0, 0,  0,  0,  0, 32'hFC03,      32'hDEAD_BEEF));
        tbl.push_back(mk(0, 12, 32'h0,         32'h0,        0, 0,  0,  0,  0, 32'h0,         32'hDEAD_BEEF));
        tbl.push_back(mk(0, 14, 32'h0,         32'h0,        1, 12, 0,  0,  1, 32'hDEAD_BEEF, 32'hDEAD_BEEF));
        tbl.push_back(mk(0, 14, 32'h0,         32'h0,        0, 0,  0,  0,  0, 32'hFFFF_FFFC, 32'hFFFF_FFFC));
        tbl.push_back(mk(0, 13, 32'h0,         32'h0,        0, 0,  0,  0,  0, 32'h8000_0030, 32'hFFFF_FFFC));
        tbl.push_back(mk(0, 14, 32'h0,         32'h5000,     0, 10, 0,  0,  0, 32'hFFFF_FFFC, 32'hFFFF_FFFC));
        tbl.push_back(mk(0, 13, 32'h0,         32'h0,        0, 0,  0,  0,  0, 32'h8000_0030, 32'hFFFF_FFFC));

        #2;
        chk("rst_req",  {31'b0, req}, 32'h0);
        chk("rst_sr",   dout,         32'h0);
        chk("rst_epc",  epc_out,      32'h0);
        chk("hpc",      handler_pc,   HPC);
        addr = 5'd15;
        #1;
        chk("rst_prid", dout,         PRID);

        #3 reset_n = 1'b1;
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            e.tag = $sformatf("v%0d", i);
            e.req = tbl[i].req; e.dout = tbl[i].dout; e.epc = tbl[i].epc;
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front();
            chk({e.tag, "_req"},  {31'b0, req}, {31'b0, e.req});
            chk({e.tag, "_dout"}, dout,         e.dout);
            chk({e.tag, "_epc"},  epc_out,      e.epc);
            @(posedge clk);
            #1;
        end

        // Reset asserted mid-cycle while EXL=1: state clears before the next edge.
        idle();
        addr = 5'd12;
        #1 chk("pre_rst_exl", dout, 32'h2);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_sr",  dout,         32'h0);
        chk("mid_rst_req", {31'b0, req}, 32'h0);
        chk("mid_rst_epc", epc_out,      32'h0);
        addr = 5'd13;
        #1 chk("mid_rst_cause", dout, 32'h0);
        addr = 5'd14;
        #1 chk("mid_rst_epcr",  dout, 32'h0);
        addr = 5'd15;
        #1 chk("mid_rst_prid",  dout, PRID);
        #1 reset_n = 1'b1;

        // Pending interrupt drops the instant reset asserts.
        we = 1'b1; addr = 5'd12; din = 32'h0000_0401; hwint = 6'b000001;
        @(posedge clk);
        #1 we = 1'b0;
        #1 chk("int_req_on", {31'b0, req}, 32'h1);
        #1 reset_n = 1'b0;
        #1 chk("rst_drop_req", {31'b0, req}, 32'h0);
        chk("rst_drop_sr", dout, 32'h0);
        #1 reset_n = 1'b1;
        idle();

`ifdef CP0_TIMER_EN
        reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        we = 1'b1; addr = 5'd11; din = 32'd5;
        @(posedge clk);
        #1 din = 32'h0000_8001; addr = 5'd12;
        @(posedge clk);
        #1 we = 1'b0; addr = 5'd13;
        for (int k = 2; k <= 8; k++) begin
            chk($sformatf("tmr_req_c%0d", k), {31'b0, req}, {31'b0, (k == 7)});
            @(posedge clk);
            #1;
        end
        we = 1'b1; addr = 5'd11; din = 32'h100;
        @(posedge clk);
        #1 we = 1'b0; eret = 1'b0;
        @(posedge clk);
        #1 eret = 1'b1;
        @(posedge clk);
        #1 eret = 1'b0; addr = 5'd13;
        #1;
        chk("tmr_clr_req",   {31'b0, req}, 32'h0);
        chk("tmr_clr_cause", dout,         32'h0);
        addr = 5'd11;
        #1 chk("tmr_compare", dout, 32'h100);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
